// File: rtl/ast_dmx_buf.sv
// Avalon-ST 1-to-TX_DIR demultiplexer: routes whole packets by the dir_i captured on SOP,
// with a 2-entry skid FIFO per output so the sink ready never depends on any source ready.
module ast_dmx_buf #(
    parameter int DATA_W    = 64,
    parameter int CHANNEL_W = 8,
    parameter int TX_DIR    = 4,
    localparam int EMPTY_W   = $clog2(DATA_W / 8),
    localparam int DIR_SEL_W = (TX_DIR > 2) ? $clog2(TX_DIR) : 1
) (
    input  logic                 clk_i,
    input  logic                 srst_n_i,
    input  logic [DIR_SEL_W-1:0] dir_i,
    input  logic [DATA_W-1:0]    ast_data_i,
    input  logic                 ast_startofpacket_i,
    input  logic                 ast_endofpacket_i,
    input  logic                 ast_valid_i,
    input  logic [EMPTY_W-1:0]   ast_empty_i,
    input  logic [CHANNEL_W-1:0] ast_channel_i,
    output logic                 ast_ready_o,
    output logic [DATA_W-1:0]    ast_data_o          [TX_DIR],
    output logic                 ast_startofpacket_o [TX_DIR],
    output logic                 ast_endofpacket_o   [TX_DIR],
    output logic                 ast_valid_o         [TX_DIR],
    output logic [EMPTY_W-1:0]   ast_empty_o         [TX_DIR],
    output logic [CHANNEL_W-1:0] ast_channel_o       [TX_DIR],
    input  logic                 ast_ready_i         [TX_DIR],
    output logic                 pkt_drop_o
);
    localparam int ENTRY_W = DATA_W + 2 + EMPTY_W + CHANNEL_W;
    localparam int SEL_N   = 1 << DIR_SEL_W;
    localparam logic [DIR_SEL_W:0] TX_DIR_L = (DIR_SEL_W + 1)'(TX_DIR);

    typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

    state_t               state_reg, state_next;
    logic [DIR_SEL_W-1:0] cur_dir_reg, cur_dir_next;
    logic                 drop_reg, drop_next;
    logic                 accept;
    logic                 push_en;
    logic [DIR_SEL_W-1:0] push_dir;
    logic                 dir_ok;
    logic [1:0]           count [TX_DIR];
    logic [SEL_N-1:0]     not_full_pad;
    logic [ENTRY_W-1:0]   in_word;

    assign in_word = {ast_data_i, ast_startofpacket_i, ast_endofpacket_i, ast_empty_i, ast_channel_i};
    assign dir_ok  = ({1'b0, dir_i} < TX_DIR_L);
    assign accept  = ast_valid_i & ast_ready_o;

    // Unused select codes read as "not full" so an out-of-range SOP can always be taken and dropped.
    always_comb begin
        not_full_pad = '1;
        for (int k = 0; k < TX_DIR; k++) begin
            not_full_pad[k] = (count[k] != 2'd2);
        end
    end

    always_comb begin
        ast_ready_o = 1'b1;
        case (state_reg)
            IDLE:    ast_ready_o = not_full_pad[dir_i];
            PASS:    ast_ready_o = not_full_pad[cur_dir_reg];
            default: ast_ready_o = 1'b1;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        cur_dir_next = cur_dir_reg;
        drop_next    = 1'b0;
        push_en      = 1'b0;
        push_dir     = cur_dir_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (!ast_startofpacket_i) begin
                        drop_next = 1'b1;
                    end else if (dir_ok) begin
                        cur_dir_next = dir_i;
                        push_en      = 1'b1;
                        push_dir     = dir_i;
                        if (!ast_endofpacket_i) state_next = PASS;
                    end else begin
                        drop_next = 1'b1;
                        if (!ast_endofpacket_i) state_next = DROP;
                    end
                end
            end
            PASS: begin
                if (accept) begin
                    push_en = 1'b1;
                    if (ast_endofpacket_i) state_next = IDLE;
                end
            end
            DROP: begin
                if (accept && ast_endofpacket_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state_reg   <= IDLE;
            cur_dir_reg <= '0;
            drop_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cur_dir_reg <= cur_dir_next;
            drop_reg    <= drop_next;
        end
    end

    assign pkt_drop_o = drop_reg;

    for (genvar gi = 0; gi < TX_DIR; gi++) begin : g_buf
        logic [ENTRY_W-1:0] mem_reg [2];
        logic               rd_ptr_reg, wr_ptr_reg;
        logic [1:0]         count_reg;
        logic               push, pop;
        logic [ENTRY_W-1:0] head;

        assign push = push_en && (push_dir == DIR_SEL_W'(gi));
        assign pop  = (count_reg != 2'd0) && ast_ready_i[gi];
        assign head = mem_reg[rd_ptr_reg];

        always_ff @(posedge clk_i) begin
            if (push) mem_reg[wr_ptr_reg] <= in_word;
        end

        always_ff @(posedge clk_i) begin
            if (!srst_n_i) begin
                rd_ptr_reg <= 1'b0;
                wr_ptr_reg <= 1'b0;
                count_reg  <= 2'd0;
            end else begin
                if (push) wr_ptr_reg <= ~wr_ptr_reg;
                if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
                count_reg <= count_reg + 2'(push) - 2'(pop);
            end
        end

        assign count[gi]               = count_reg;
        assign ast_valid_o[gi]         = (count_reg != 2'd0);
        assign ast_data_o[gi]          = head[ENTRY_W-1 -: DATA_W];
        assign ast_startofpacket_o[gi] = head[CHANNEL_W + EMPTY_W + 1];
        assign ast_endofpacket_o[gi]   = head[CHANNEL_W + EMPTY_W];
        assign ast_empty_o[gi]         = head[CHANNEL_W +: EMPTY_W];
        assign ast_channel_o[gi]       = head[CHANNEL_W-1:0];
    end
endmodule

// File: tb/tb_ast_dmx_buf.sv
// Bench for ast_dmx_buf: vector table, directed corner sequences and random traffic
// checked cycle by cycle against a packet-level queue model.
module tb_ast_dmx_buf;
    localparam int TXD = 4;

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
        logic [7:0]  channel;
    } word_t;

    typedef struct {
        logic [1:0]  dir;
        logic [63:0] data;
        logic        sop;
        logic        eop;
        int          exp_port;
        logic        exp_drop;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        srst_n, sop, eop, valid;
    logic [1:0]  dir;
    logic [63:0] data;
    logic [2:0]  empty;
    logic [7:0]  chan;
    logic        ready_o, drop;
    logic [63:0] d_data  [TXD];
    logic        d_sop   [TXD];
    logic        d_eop   [TXD];
    logic        d_valid [TXD];
    logic [2:0]  d_empty [TXD];
    logic [7:0]  d_chan  [TXD];
    logic        rdy_i   [TXD];

    logic [1:0]  dir3;
    logic        valid3, ready3_o, drop3;
    logic [63:0] e_data  [3];
    logic        e_sop   [3];
    logic        e_eop   [3];
    logic        e_valid [3];
    logic [2:0]  e_empty [3];
    logic [7:0]  e_chan  [3];
    logic        rdy3    [3];

    ast_dmx_buf #(.DATA_W(64), .CHANNEL_W(8), .TX_DIR(TXD)) dut (
        .clk_i(clk), .srst_n_i(srst_n), .dir_i(dir),
        .ast_data_i(data), .ast_startofpacket_i(sop), .ast_endofpacket_i(eop),
        .ast_valid_i(valid), .ast_empty_i(empty), .ast_channel_i(chan),
        .ast_ready_o(ready_o),
        .ast_data_o(d_data), .ast_startofpacket_o(d_sop), .ast_endofpacket_o(d_eop),
        .ast_valid_o(d_valid), .ast_empty_o(d_empty), .ast_channel_o(d_chan),
        .ast_ready_i(rdy_i), .pkt_drop_o(drop)
    );

    ast_dmx_buf #(.DATA_W(64), .CHANNEL_W(8), .TX_DIR(3)) dut3 (
        .clk_i(clk), .srst_n_i(srst_n), .dir_i(dir3),
        .ast_data_i(data), .ast_startofpacket_i(sop), .ast_endofpacket_i(eop),
        .ast_valid_i(valid3), .ast_empty_i(empty), .ast_channel_i(chan),
        .ast_ready_o(ready3_o),
        .ast_data_o(e_data), .ast_startofpacket_o(e_sop), .ast_endofpacket_o(e_eop),
        .ast_valid_o(e_valid), .ast_empty_o(e_empty), .ast_channel_o(e_chan),
        .ast_ready_i(rdy3), .pkt_drop_o(drop3)
    );

    int    checks = 0;
    int    failures = 0;
    bit    model_on = 1'b0;
    word_t q [TXD][$];
    int    m_mode = 0;       // 0 between packets, 1 forwarding, 2 discarding
    int    m_dest = 0;
    bit    m_drop_exp = 1'b0;
    int    rx_cnt [TXD];
    vec_t  tbl [6];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: compare DUT against the model at the falling edge, advance the model
    // by what the rising edge does, and return 1 ns after that edge.
    task automatic tick();
        bit    exp_rdy, drop_n;
        word_t act, w;
        @(negedge clk);
        for (int k = 0; k < TXD; k++)
            if (srst_n && d_valid[k] && rdy_i[k]) rx_cnt[k]++;
        if (m_mode == 2)      exp_rdy = 1'b1;
        else if (m_mode == 1) exp_rdy = (q[m_dest].size() < 2);
        else                  exp_rdy = (q[int'(dir)].size() < 2);
        if (model_on) begin
            chk("pkt_drop", 80'(drop), 80'(m_drop_exp));
            chk("ready_o", 80'(ready_o), 80'(exp_rdy));
            for (int k = 0; k < TXD; k++) begin
                chk($sformatf("valid[%0d]", k), 80'(d_valid[k]), 80'(q[k].size() > 0));
                if (q[k].size() > 0) begin
                    act = {d_data[k], d_sop[k], d_eop[k], d_empty[k], d_chan[k]};
                    chk($sformatf("word[%0d]", k), 80'(act), 80'(q[k][0]));
                end
            end
        end
        drop_n = 1'b0;
        if (!srst_n) begin
            for (int k = 0; k < TXD; k++) q[k].delete();
            m_mode = 0;
            m_dest = 0;
        end else begin
            for (int k = 0; k < TXD; k++)
                if (q[k].size() > 0 && rdy_i[k]) void'(q[k].pop_front());
            if (valid && exp_rdy) begin
                w = {data, sop, eop, empty, chan};
                if (m_mode == 0) begin
                    if (sop) begin
                        q[int'(dir)].push_back(w);
                        if (!eop) begin
                            m_mode = 1;
                            m_dest = int'(dir);
                        end
                    end else begin
                        drop_n = 1'b1;
                    end
                end else if (m_mode == 1) begin
                    q[m_dest].push_back(w);
                    if (eop) m_mode = 0;
                end else if (eop) begin
                    m_mode = 0;
                end
            end
        end
        m_drop_exp = drop_n;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic s, input logic e, input logic [1:0] dr,
                        input logic [63:0] dt, input bit rand_rdy1);
        bit done = 1'b0;
        sop = s; eop = e; dir = dr; data = dt;
        empty = 3'(dt); chan = 8'(dt >> 8); valid = 1'b1;
        for (int t = 0; t < 64 && !done; t++) begin
            if (rand_rdy1) rdy_i[1] = 1'($urandom_range(0, 1));
            #1;
            done = ready_o;
            tick();
        end
        chk("send_timeout", 80'(done), 80'(1));
        valid = 1'b0;
    endtask

    initial begin
        int base0, base1, base3, pulses;
        srst_n = 1'b0; valid = 1'b0; sop = 1'b0; eop = 1'b0; dir = 2'd0;
        data = '0; empty = '0; chan = '0; dir3 = 2'd0; valid3 = 1'b0;
        for (int k = 0; k < TXD; k++) begin rdy_i[k] = 1'b1; rx_cnt[k] = 0; end
        for (int k = 0; k < 3; k++) rdy3[k] = 1'b1;
        tick();
        tick();
        model_on = 1'b1;
        srst_n = 1'b1;
        for (int k = 0; k < TXD; k++) chk($sformatf("rst_valid[%0d]", k), 80'(d_valid[k]), 80'(0));
        chk("rst_drop", 80'(drop), 80'(0));
        chk("rst_ready", 80'(ready_o), 80'(1));

        // single-word vectors: routed packets, orphans, and routing right after an orphan
        tbl[0] = '{2'd2, 64'hA5,               1'b1, 1'b1,  2, 1'b0};
        tbl[1] = '{2'd0, 64'h11,               1'b0, 1'b0, -1, 1'b1};
        tbl[2] = '{2'd1, 64'h2222_0000_0000_22, 1'b1, 1'b1,  1, 1'b0};
        tbl[3] = '{2'd3, 64'hFFFF_FFFF_FFFF_FF33, 1'b1, 1'b1,  3, 1'b0};
        tbl[4] = '{2'd0, 64'h44,               1'b0, 1'b1, -1, 1'b1};
        tbl[5] = '{2'd0, 64'h55,               1'b1, 1'b1,  0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            dir = tbl[i].dir; data = tbl[i].data; sop = tbl[i].sop; eop = tbl[i].eop;
            empty = 3'd5; chan = 8'(i); valid = 1'b1;
            tick();
            valid = 1'b0;
            for (int k = 0; k < TXD; k++)
                chk($sformatf("vec%0d_valid[%0d]", i, k), 80'(d_valid[k]), 80'(k == tbl[i].exp_port));
            if (tbl[i].exp_port >= 0)
                chk($sformatf("vec%0d_data", i), 80'(d_data[tbl[i].exp_port]), 80'(tbl[i].data));
            chk($sformatf("vec%0d_drop", i), 80'(drop), 80'(tbl[i].exp_drop));
            tick();
            for (int k = 0; k < TXD; k++)
                chk($sformatf("vec%0d_after[%0d]", i, k), 80'(d_valid[k]), 80'(0));
        end

        // 8-word packet to port 1 with a randomly stalling sink
        base1 = rx_cnt[1];
        for (int i = 0; i < 8; i++) send(i == 0, i == 7, 2'd1, 64'(100 + i), 1'b1);
        rdy_i[1] = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("pkt8_count", 80'(rx_cnt[1] - base1), 80'(8));

        // port 0 stalled with a 2-word packet held; port 3 packet still gets through
        rdy_i[0] = 1'b0;
        base0 = rx_cnt[0]; base3 = rx_cnt[3];
        send(1'b1, 1'b0, 2'd0, 64'h0A0, 1'b0);
        send(1'b0, 1'b1, 2'd0, 64'h0A1, 1'b0);
        send(1'b1, 1'b0, 2'd3, 64'h3B0, 1'b0);
        send(1'b0, 1'b0, 2'd0, 64'h3B1, 1'b0);
        send(1'b0, 1'b1, 2'd1, 64'h3B2, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        chk("hol_port3_count", 80'(rx_cnt[3] - base3), 80'(3));
        chk("hol_port0_count", 80'(rx_cnt[0] - base0), 80'(0));
        chk("hol_port0_valid", 80'(d_valid[0]), 80'(1));
        chk("hol_port0_head", 80'(d_data[0]), 80'(64'h0A0));
        rdy_i[0] = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("hol_port0_drain", 80'(rx_cnt[0] - base0), 80'(2));

        // out-of-range destination on a 3-port instance
        pulses = 0;
        dir3 = 2'd3;
        for (int i = 0; i < 5; i++) begin
            valid3 = (i < 4); sop = (i == 0); eop = (i == 3); data = 64'(i);
            #1;
            if (i < 4) chk($sformatf("oor_ready%0d", i), 80'(ready3_o), 80'(1));
            tick();
            if (drop3) pulses++;
            for (int k = 0; k < 3; k++)
                chk($sformatf("oor_valid%0d[%0d]", i, k), 80'(e_valid[k]), 80'(0));
        end
        valid3 = 1'b0;
        chk("oor_drop_pulses", 80'(pulses), 80'(1));

        // reset on word 3 of a 6-word packet, remaining words become orphans
        rdy_i[2] = 1'b0;
        send(1'b1, 1'b0, 2'd2, 64'h600, 1'b0);
        send(1'b0, 1'b0, 2'd2, 64'h601, 1'b0);
        chk("mid_held", 80'(d_valid[2]), 80'(1));
        sop = 1'b0; eop = 1'b0; data = 64'h602; valid = 1'b1; srst_n = 1'b0;
        tick();
        srst_n = 1'b1;
        for (int k = 0; k < TXD; k++) chk($sformatf("mid_rst_valid[%0d]", k), 80'(d_valid[k]), 80'(0));
        rdy_i[2] = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            valid = (i < 3); eop = (i == 2); data = 64'(16'h603 + i);
            tick();
            if (drop) pulses++;
            for (int k = 0; k < TXD; k++) chk($sformatf("mid_orphan_valid[%0d]", k), 80'(d_valid[k]), 80'(0));
        end
        valid = 1'b0;
        chk("mid_drop_pulses", 80'(pulses), 80'(3));

        // random traffic, occasional resets
        for (int c = 0; c < 800; c++) begin
            valid = ($urandom_range(0, 3) != 0);
            sop   = ($urandom_range(0, 3) == 0);
            eop   = ($urandom_range(0, 3) == 0);
            dir   = 2'($urandom);
            data  = {$urandom, $urandom};
            empty = 3'($urandom);
            chan  = 8'($urandom);
            for (int k = 0; k < TXD; k++) rdy_i[k] = ($urandom_range(0, 9) < 7);
            srst_n = ($urandom_range(0, 99) != 0);
            tick();
        end
        srst_n = 1'b1; valid = 1'b0;
        for (int k = 0; k < TXD; k++) rdy_i[k] = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ast_dmx_buf.md
AST_DMX_BUF -- requirements
Module: ast_dmx_buf

Interface
REQ-001 The module SHALL have parameter DATA_W, default 64, meaning the data bus width in bits (multiple of 8).
REQ-002 The module SHALL have parameter CHANNEL_W, default 8, meaning the channel field width.
REQ-003 The module SHALL have parameter TX_DIR, default 4, meaning the number of output ports (2..16).
REQ-004 The module SHALL derive localparams EMPTY_W = $clog2(DATA_W/8) and DIR_SEL_W = $clog2(TX_DIR) (minimum 1).
REQ-005 The module SHALL have port clk_i, input, width 1, carrying the single clock; all logic is rising-edge.
REQ-006 The module SHALL have port srst_n_i, input, width 1, carrying a synchronous active-low reset.
REQ-007 The module SHALL have port dir_i, input, DIR_SEL_W bits, carrying the destination, sampled on the accepted SOP word.
REQ-008 The module SHALL have input ports ast_data_i (DATA_W), ast_startofpacket_i (1), ast_endofpacket_i (1), ast_valid_i (1), ast_empty_i (EMPTY_W) and ast_channel_i (CHANNEL_W), forming the sink Avalon-ST bus.
REQ-009 The module SHALL have port ast_ready_o, output, width 1, carrying the sink ready.
REQ-010 The module SHALL have output ports ast_data_o, ast_startofpacket_o, ast_endofpacket_o, ast_valid_o, ast_empty_o and ast_channel_o, each an unpacked array [TX_DIR] of the matching input width, forming the source buses.
REQ-011 The module SHALL have port ast_ready_i, input, [TX_DIR] x 1, carrying the per-source ready.
REQ-012 The module SHALL have port pkt_drop_o, output, width 1, carrying a one-cycle pulse per dropped packet or orphan word.

Function
REQ-013 A word SHALL be accepted when ast_valid_i & ast_ready_o are high on a rising edge.
REQ-014 The control FSM SHALL have three states: IDLE, PASS and DROP.
REQ-015 In IDLE, an accepted SOP word with dir_i < TX_DIR SHALL latch cur_dir = dir_i, push the word into buffer[dir_i] and go to PASS.
REQ-016 In IDLE, an accepted SOP word with dir_i >= TX_DIR SHALL be discarded, pulse pkt_drop_o and go to DROP.
REQ-017 In IDLE, an accepted word without SOP SHALL be discarded, pulse pkt_drop_o and leave the state at IDLE.
REQ-018 A word with both SOP and EOP SHALL be processed as in REQ-015/016 but the FSM SHALL stay in IDLE.
REQ-019 In PASS, every accepted word SHALL be pushed to buffer[cur_dir]; an accepted EOP word SHALL return the FSM to IDLE, and dir_i SHALL be ignored.
REQ-020 In DROP, ast_ready_o SHALL be 1 and words SHALL be discarded; an accepted EOP word SHALL return the FSM to IDLE.
REQ-021 A SOP arriving in PASS or DROP SHALL be treated as data (no re-routing) and SHALL NOT pulse pkt_drop_o.
REQ-022 Each output SHALL own a 2-entry FIFO (skid buffer) storing {data, sop, eop, empty, channel}.
REQ-023 ast_valid_o[k] SHALL be 1 iff buffer[k] is non-empty, and the source fields SHALL show its head entry.
REQ-024 buffer[k] SHALL pop when ast_valid_o[k] & ast_ready_i[k] are high.
REQ-025 A simultaneous push and pop SHALL keep the count unchanged and preserve order.
REQ-026 ast_ready_o SHALL be 1 in DROP, (count[dir_i] < 2) in IDLE (0 if dir_i >= TX_DIR is not applicable: then 1), and (count[cur_dir] < 2) in PASS.
REQ-027 ast_ready_o SHALL have no combinational path from any ast_ready_i.
REQ-028 Latency SHALL be one cycle: a word accepted into an empty buffer at edge N SHALL be visible at the source after edge N.
REQ-029 Buffers of non-selected outputs SHALL keep draining independently while another port receives.
REQ-030 Full throughput SHALL be sustained, i.e. one word/cycle when the selected ast_ready_i is held at 1.

Reset
REQ-031 On srst_n_i = 0 at an edge, the FSM SHALL go to IDLE, all buffers SHALL be flushed (all ast_valid_o = 0), pkt_drop_o SHALL be 0 and cur_dir SHALL be 0.
REQ-032 A reset mid-packet SHALL discard the partial packet, and the next accepted word SHALL require SOP to be routed.
REQ-033 Data/sop/eop/empty/channel outputs are don't-care while valid is 0.

Verification
REQ-034 Apply a single-word packet, dir_i=2, data=0xA5, SOP=EOP=1, all readies 1 -> ast_valid_o[2]=1 for exactly one cycle, one cycle later, with data 0xA5; other valids 0.
REQ-035 Apply an 8-word packet to dir 1 with ast_ready_i[1] toggling randomly -> all 8 words arrive in order, no loss or duplication, and ast_ready_o falls within 2 words of the stall.
REQ-036 Apply back-to-back packets to dir 0 then dir 3, with ast_ready_i[0]=0 -> the dir 3 packet completes while 2 words of the dir 0 packet remain held.
REQ-037 With TX_DIR=3, send a 4-word packet with dir_i=3 -> ast_ready_o=1 throughout, one pkt_drop_o pulse, and no output valid.
REQ-038 Send an orphan word (no SOP) in IDLE -> one pkt_drop_o pulse, and the following SOP packet is routed normally.
REQ-039 Assert srst_n_i on word 3 of a 6-word packet -> all valids 0 next cycle, and words 4-6 without SOP are dropped, one pkt_drop_o pulse each.
